// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud timing helpers.
// The TX wrapper uses the same package.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned half_bit(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clks_per_bit(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a zeroed head output when empty.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        // A pop in the same cycle frees the slot the push is about to use.
        do_push = push && (!full || do_pop);
        head    = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: synchronizer, frame FSM, receive FIFO and
// sticky overrun / framing-error flags polled by software.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] rd_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       frame_err
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned HALF_BIT     = half_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);

    rx_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             rx_meta, rx_s, rx_q;
    logic             overrun_q, frame_err_q;
    logic             fifo_full, fifo_empty;
    logic             half_done, bit_done, stop_sample, push, set_ovr, set_ferr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    always_comb begin
        half_done   = (cnt_q == CNT_W'(HALF_BIT - 1));
        bit_done    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        stop_sample = (state_q == STOP) && bit_done;
        // A full FIFO still accepts the byte when software pops in the same cycle.
        push        = stop_sample && rx_s && (!fifo_full || rd);
        set_ovr     = stop_sample && rx_s && fifo_full && !rd;
        set_ferr    = stop_sample && !rx_s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (set_ovr)      overrun_q <= 1'b1;
            else if (clr_err) overrun_q <= 1'b0;
            if (set_ferr)     frame_err_q <= 1'b1;
            else if (clr_err) frame_err_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    // Edge-triggered so a held-low break line cannot retrigger.
                    if (rx_q && !rx_s) begin
                        cnt_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (half_done) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (shift_q),
        .pop     (rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (rd_data)
    );

    assign rx_valid  = !fifo_empty;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: frame-level reference model compared every
// cycle, plus hand-computed literal checks for each scenario.
module tb_uart_rx_mmio;

    localparam int CPB      = 104;                  // 12 MHz / 115200, truncated
    localparam int HALF     = 52;
    localparam int DEPTH    = 4;
    localparam int PUSH_LAT = 3 + HALF + 9 * CPB;   // 2 sync flops + edge detect, then bit centres

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid, overrun, frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Reference model state: received bytes, sticky flags, scheduled stop samples.
    logic [7:0] mq[$];
    bit         m_ovr = 1'b0;
    bit         m_ferr = 1'b0;
    int         ev_cyc[$];
    logic [7:0] ev_byte[$];
    bit         ev_good[$];

    uart_rx_mmio dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .rd        (rd),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        int  pre;
        bit  set_o, set_f;
        cyc = cyc + 1;
        if (reset_n) begin
            pre   = mq.size();
            set_o = 1'b0;
            set_f = 1'b0;
            if (rd && pre > 0) void'(mq.pop_front());
            while (ev_cyc.size() > 0 && ev_cyc[0] <= cyc) begin
                if (!ev_good[0])                 set_f = 1'b1;
                else if (pre < DEPTH || rd)      mq.push_back(ev_byte[0]);
                else                             set_o = 1'b1;
                void'(ev_cyc.pop_front());
                void'(ev_byte.pop_front());
                void'(ev_good.pop_front());
            end
            if (set_o) m_ovr = 1'b1; else if (clr_err) m_ovr = 1'b0;
            if (set_f) m_ferr = 1'b1; else if (clr_err) m_ferr = 1'b0;
        end
    end

    always @(negedge reset_n) begin
        mq.delete();
        ev_cyc.delete();
        ev_byte.delete();
        ev_good.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model rx_valid", {7'd0, rx_valid}, {7'd0, mq.size() > 0});
            check("model rd_data", rd_data, (mq.size() > 0) ? mq[0] : 8'h00);
            check("model overrun", {7'd0, overrun}, {7'd0, m_ovr});
            check("model frame_err", {7'd0, frame_err}, {7'd0, m_ferr});
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int hold_low);
        @(posedge clk); #1;
        ev_cyc.push_back(cyc + PUSH_LAT);
        ev_byte.push_back(b);
        ev_good.push_back(stop_bit);
        rx = 1'b0;
        repeat (CPB) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk); #1;
        end
        rx = stop_bit;
        repeat (CPB) @(posedge clk); #1;
        if (!stop_bit) begin
            repeat (hold_low) @(posedge clk); #1;
        end
        rx = 1'b1;
    endtask

    task automatic pop_byte();
        @(posedge clk); #1 rd = 1'b1;
        @(posedge clk); #1 rd = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        check("reset rx_valid", {7'd0, rx_valid}, 8'd0);
        check("reset rd_data", rd_data, 8'h00);
        check("reset flags", {6'd0, overrun, frame_err}, 8'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);

        // Single frame, exact latency to rx_valid.
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                @(posedge clk);
                repeat (PUSH_LAT - 1) @(posedge clk);
                #1 check("a5 not yet valid", {7'd0, rx_valid}, 8'd0);
                @(posedge clk);
                #1 check("a5 valid", {7'd0, rx_valid}, 8'd1);
                check("a5 data", rd_data, 8'hA5);
            end
        join
        pop_byte();
        check("a5 popped", {7'd0, rx_valid}, 8'd0);

        // Five frames without reads: fifth is dropped.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
        check("burst overrun", {7'd0, overrun}, 8'd1);
        for (int i = 1; i <= 4; i++) begin
            check("burst order", rd_data, 8'(i));
            pop_byte();
        end
        check("burst drained", {7'd0, rx_valid}, 8'd0);
        pulse_clr();
        check("overrun cleared", {7'd0, overrun}, 8'd0);

        // Framing error, then line held low as a break.
        fork
            send_frame(8'h3C, 1'b0, 1200);
            begin
                @(posedge clk);
                repeat (PUSH_LAT + 10) @(posedge clk);
                #1 check("ferr set", {7'd0, frame_err}, 8'd1);
                check("ferr no push", {7'd0, rx_valid}, 8'd0);
                pulse_clr();
                check("ferr cleared", {7'd0, frame_err}, 8'd0);
            end
        join
        repeat (20) @(posedge clk);
        check("break no retrigger", {7'd0, frame_err}, 8'd0);
        send_frame(8'h81, 1'b1, 0);
        check("after break data", rd_data, 8'h81);
        pop_byte();

        // Short glitch on an idle line.
        @(posedge clk); #1 rx = 1'b0;
        repeat (30) @(posedge clk); #1 rx = 1'b1;
        repeat (1100) @(posedge clk); #1;
        check("glitch no push", {7'd0, rx_valid}, 8'd0);
        check("glitch no flags", {6'd0, overrun, frame_err}, 8'd0);

        // Full FIFO with a pop coinciding with the next push.
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 0);
        fork
            send_frame(8'h77, 1'b1, 0);
            begin
                @(posedge clk);
                repeat (PUSH_LAT - 1) @(posedge clk);
                #1 rd = 1'b1;
                @(posedge clk);
                #1 rd = 1'b0;
            end
        join
        check("full+pop no overrun", {7'd0, overrun}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            check("full+pop order", rd_data, (i == 3) ? 8'h77 : 8'h11 + 8'(i));
            pop_byte();
        end
        check("full+pop drained", {7'd0, rx_valid}, 8'd0);

        // Reset mid-DATA with a byte already buffered.
        send_frame(8'h42, 1'b1, 0);
        check("pre-reset data", rd_data, 8'h42);
        @(posedge clk); #1 rx = 1'b0;
        repeat (CPB) @(posedge clk); #1 rx = 1'b1;
        repeat (4 * CPB + HALF) @(posedge clk); #1 reset_n = 1'b0;
        #1;
        check("midreset rx_valid", {7'd0, rx_valid}, 8'd0);
        check("midreset rd_data", rd_data, 8'h00);
        check("midreset flags", {6'd0, overrun, frame_err}, 8'd0);
        repeat (3) @(posedge clk); #1 reset_n = 1'b1;
        repeat (5 * CPB) @(posedge clk);
        check("post-reset idle", {7'd0, rx_valid}, 8'd0);
        send_frame(8'h5A, 1'b1, 0);
        check("post-reset data", rd_data, 8'h5A);
        pop_byte();
        check("post-reset drained", {7'd0, rx_valid}, 8'd0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
